// File: rtl/fp_div_arb.sv
// fp_div_arb: round-robin arbiter sharing one iterative fp divider among NREQ requesters.
// Optional watchdog: define FP_DIV_ARB_TIMEOUT_EN to bound the divider wait to TIMEOUT_CYC cycles.
module fp_div_arb #(
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_vld,
  output logic [NREQ-1:0]      req_rdy,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic                 rsp_vld,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_c,
  output logic                 rsp_err,
  output logic                 div_arg_vld,
  input  logic                 div_busy,
  input  logic                 div_res_vld,
  output logic [31:0]          div_a,
  output logic [31:0]          div_b,
  input  logic [31:0]          div_c
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_RES, RESP} state_t;
  state_t state;
  logic [IDW-1:0] ptr, id, gid, cand;
  logic [NREQ-1:0] gnt;
  logic [31:0] op_a, op_b;
  if (NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ) || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("fp_div_arb: inconsistent parameters");
  end
`ifdef FP_DIV_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  logic err;
  assign rsp_err = err;
`else
  assign rsp_err = 1'b0;
`endif
  // Scan from the farthest offset down so the closest requester to ptr wins.
  always_comb begin
    gnt = '0;
    gid = '0;
    cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (req_vld[cand]) begin
        gnt = '0;
        gnt[cand] = 1'b1;
        gid = cand;
      end
    end
  end
  assign req_rdy     = (state == IDLE && !rst) ? gnt : '0;
  assign div_arg_vld = state == ISSUE && !div_busy;
  assign rsp_vld     = state == RESP;
  assign div_a       = op_a;
  assign div_b       = op_b;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      id     <= '0;
      op_a   <= '0;
      op_b   <= '0;
      rsp_c  <= '0;
      rsp_id <= '0;
`ifdef FP_DIV_ARB_TIMEOUT_EN
      cnt    <= '0;
      err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (|gnt) begin
          op_a  <= req_a[32*gid +: 32];
          op_b  <= req_b[32*gid +: 32];
          id    <= gid;
          state <= ISSUE;
        end
        ISSUE:     if (!div_busy) state <= WAIT_BUSY;
        // A leftover res_vld from the previous divide is only trusted after a fresh busy rise.
        WAIT_BUSY: if (div_busy) state <= WAIT_RES;
        WAIT_RES: if (!div_busy && div_res_vld) begin
          rsp_c  <= div_c;
          rsp_id <= id;
          state  <= RESP;
        end
        RESP: begin
          ptr   <= (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef FP_DIV_ARB_TIMEOUT_EN
      if (state == ISSUE) cnt <= '0;
      if (state == RESP) err <= 1'b0;
      if (state == WAIT_BUSY || state == WAIT_RES) begin
        if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          state  <= RESP;
          rsp_c  <= 32'h7FC00000;
          rsp_id <= id;
          err    <= 1'b1;
        end else cnt <= cnt + 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_fp_div_arb.sv
// tb_fp_div_arb: directed bench for fp_div_arb with a behavioural iterative-divider model.
module tb_fp_div_arb;
  logic clk = 0, rst = 1;
  logic [3:0] req_vld = 0, req_rdy;
  logic [127:0] req_a = 0, req_b = 0;
  logic rsp_vld, rsp_err, div_arg_vld, div_busy, div_res_vld;
  logic [1:0] rsp_id;
  logic [31:0] rsp_c, div_a, div_b, div_c;
  int tests = 0, fails = 0;
  logic m_busy = 0, m_pend = 0, m_res = 0;
  logic [31:0] m_c = 0, next_c = 0;
  int m_cnt = 0, m_dcnt = 0, lat = 20, dly = 0;
  bit never = 0, force_busy = 0;
  always #5 clk = ~clk;
  fp_div_arb #(.NREQ(4), .IDW(2), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_c(rsp_c), .rsp_err(rsp_err),
    .div_arg_vld(div_arg_vld), .div_busy(div_busy), .div_res_vld(div_res_vld),
    .div_a(div_a), .div_b(div_b), .div_c(div_c));
  assign div_busy = m_busy | force_busy;
  assign div_res_vld = m_res;
  assign div_c = m_c;
  // Divider model: start -> dly idle cycles -> busy for lat cycles -> res_vld held until next busy.
  always @(posedge clk) begin
    if (div_arg_vld && !never) begin
      m_pend <= 1; m_dcnt <= dly;
    end else if (m_pend) begin
      if (m_dcnt == 0) begin m_pend <= 0; m_busy <= 1; m_res <= 0; m_cnt <= lat; end
      else m_dcnt <= m_dcnt - 1;
    end else if (m_busy) begin
      if (m_cnt <= 1) begin m_busy <= 0; m_res <= 1; m_c <= next_c; end
      else m_cnt <= m_cnt - 1;
    end
  end
  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic do_reset(); rst = 1; repeat (2) cyc(); rst = 0; endtask
  task automatic wait_grant(output logic [3:0] g, output bit ok);
    ok = 0; g = 0; #1;
    for (int i = 0; i < 100; i++) begin
      if (req_rdy != 0) begin g = req_rdy; ok = 1; return; end
      cyc();
    end
  endtask
  task automatic wait_rsp(output logic [1:0] id, output logic [31:0] c, output logic e,
                          output bit ok, output int rdy_seen);
    ok = 0; rdy_seen = 0; id = 0; c = 0; e = 0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (rsp_vld) begin id = rsp_id; c = rsp_c; e = rsp_err; ok = 1; return; end
      if (req_rdy != 0) rdy_seen++;
    end
  endtask
  task automatic test_reset();
    req_vld = 4'b1111; rst = 1; cyc(); cyc();
    tests++; if (req_rdy !== 4'b0000) begin fails++; $display("FAIL reset_rdy: got %b want 0000", req_rdy); end
    req_vld = 0; rst = 0; #1;
    tests++; if ({rsp_vld, rsp_err, div_arg_vld} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {rsp_vld, rsp_err, div_arg_vld}); end
    tests++; if ({rsp_id, rsp_c, div_a, div_b} !== 98'd0) begin fails++; $display("FAIL reset_data: got %h want 0", {rsp_id, rsp_c, div_a, div_b}); end
  endtask
  task automatic test_single();
    logic [1:0] id; logic [31:0] c; logic e; bit ok; int rs;
    lat = 20; dly = 0; next_c = 32'h40400000;
    req_a[63:32] = 32'h40400000; req_b[63:32] = 32'h3F800000; req_vld = 4'b0010; #1;
    tests++; if (req_rdy !== 4'b0010) begin fails++; $display("FAIL single_grant: got %b want 0010", req_rdy); end
    cyc(); req_vld = 0; req_a[63:32] = 32'hDEADBEEF; #1;
    tests++; if (div_arg_vld !== 1'b1) begin fails++; $display("FAIL single_arg_vld: got %b want 1", div_arg_vld); end
    tests++; if ({div_a, div_b} !== {32'h40400000, 32'h3F800000}) begin fails++; $display("FAIL single_operands: got %h want 404000003f800000", {div_a, div_b}); end
    wait_rsp(id, c, e, ok, rs);
    tests++; if ({ok, id, c, e} !== {1'b1, 2'd1, 32'h40400000, 1'b0}) begin fails++; $display("FAIL single_rsp: got ok=%b id=%0d c=%h err=%b want ok=1 id=1 c=40400000 err=0", ok, id, c, e); end
    cyc();
    tests++; if ({rsp_vld, rsp_c} !== {1'b0, 32'h40400000}) begin fails++; $display("FAIL single_hold: got vld=%b c=%h want vld=0 c=40400000", rsp_vld, rsp_c); end
    req_vld = 4'b1111; #1;
    tests++; if (req_rdy !== 4'b0100) begin fails++; $display("FAIL single_ptr: got %b want 0100", req_rdy); end
    cyc(); req_vld = 0;
    wait_rsp(id, c, e, ok, rs);
  endtask
  task automatic test_round_robin();
    logic [3:0] g; logic [1:0] id; logic [31:0] c; logic e; bit ok; int rs;
    req_a = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    req_b = {4{32'h3F800000}};
    lat = 6; dly = 0; req_vld = 4'b1111; do_reset();
    for (int k = 0; k < 5; k++) begin
      next_c = 32'h3F800000 + k;
      wait_grant(g, ok);
      tests++; if ({ok, g} !== {1'b1, 4'(1 << (k % 4))}) begin fails++; $display("FAIL rr_grant%0d: got ok=%b g=%b want g=%b", k, ok, g, 4'(1 << (k % 4))); end
      wait_rsp(id, c, e, ok, rs);
      tests++; if ({ok, id, c, e, rs} !== {1'b1, 2'(k % 4), 32'h3F800000 + k, 1'b0, 32'd0}) begin fails++; $display("FAIL rr_rsp%0d: got ok=%b id=%0d c=%h err=%b rdy=%0d want id=%0d c=%h", k, ok, id, c, e, rs, k % 4, 32'h3F800000 + k); end
    end
    req_vld = 0;
  endtask
  task automatic test_stale_result();
    logic [3:0] g; bit ok, seen_busy = 0, seen_fall = 0, good = 0; int pulses = 0; logic [1:0] id = 0;
    lat = 8; dly = 5; next_c = 32'h41200000; req_vld = 4'b1000;
    wait_grant(g, ok);
    tests++; if ({ok, g} !== 5'b11000) begin fails++; $display("FAIL stale_grant: got ok=%b g=%b want 1000", ok, g); end
    cyc(); req_vld = 0;
    for (int i = 0; i < 80; i++) begin
      cyc();
      if (rsp_vld) begin pulses++; id = rsp_id; good = seen_fall; end
      if (div_busy) seen_busy = 1; else if (seen_busy) seen_fall = 1;
    end
    tests++; if ({pulses, good, id} !== {32'd1, 1'b1, 2'd3}) begin fails++; $display("FAIL stale_rsp: got pulses=%0d after_busy=%b id=%0d want 1 1 3", pulses, good, id); end
    dly = 0;
  endtask
  task automatic test_busy_at_issue();
    logic [1:0] id; logic [31:0] c; logic e; bit ok; int rs, bad = 0;
    lat = 6; req_vld = 4'b0001; #1;
    tests++; if (req_rdy !== 4'b0001) begin fails++; $display("FAIL busy_grant: got %b want 0001", req_rdy); end
    force_busy = 1; cyc(); req_vld = 0;
    for (int i = 0; i < 5; i++) begin if (div_arg_vld !== 1'b0) bad++; cyc(); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL busy_hold: got %0d arg_vld cycles want 0", bad); end
    force_busy = 0; #1;
    tests++; if (div_arg_vld !== 1'b1) begin fails++; $display("FAIL busy_release: got %b want 1", div_arg_vld); end
    wait_rsp(id, c, e, ok, rs);
    tests++; if ({ok, id} !== 3'b100) begin fails++; $display("FAIL busy_rsp: got ok=%b id=%0d want 1 0", ok, id); end
  endtask
  task automatic test_reset_mid();
    logic [3:0] g; logic [1:0] id; logic [31:0] c; logic e; bit ok; int rs, extra = 0;
    lat = 30; next_c = 32'h40A00000; req_vld = 4'b1111;
    wait_grant(g, ok);
    tests++; if ({ok, g} !== 5'b10010) begin fails++; $display("FAIL mid_grant: got ok=%b g=%b want 0010", ok, g); end
    for (int i = 0; i < 20 && !div_busy; i++) cyc();
    cyc(); cyc();
    rst = 1; cyc(); rst = 0; #1;
    tests++; if ({rsp_vld, rsp_err, div_arg_vld, rsp_id, rsp_c, div_a, div_b} !== 101'd0) begin fails++; $display("FAIL mid_outputs: got vld=%b id=%0d c=%h a=%h b=%h want 0", rsp_vld, rsp_id, rsp_c, div_a, div_b); end
    tests++; if (req_rdy !== 4'b0001) begin fails++; $display("FAIL mid_regrant: got %b want 0001", req_rdy); end
    cyc(); req_vld = 0;
    wait_rsp(id, c, e, ok, rs);
    tests++; if ({ok, id, c, rs} !== {1'b1, 2'd0, 32'h40A00000, 32'd0}) begin fails++; $display("FAIL mid_rsp: got ok=%b id=%0d c=%h rdy=%0d want 1 0 40a00000 0", ok, id, c, rs); end
    for (int i = 0; i < 40; i++) begin cyc(); if (rsp_vld) extra++; end
    tests++; if (extra !== 0) begin fails++; $display("FAIL mid_extra: got %0d responses want 0", extra); end
  endtask
`ifdef FP_DIV_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [3:0] g; bit ok; int n = 0;
    never = 1; req_vld = 4'b0001;
    wait_grant(g, ok);
    for (int i = 0; i < 200; i++) begin
      cyc(); n++;
      if (i == 0) req_vld = 0;
      if (rsp_vld) break;
    end
    tests++; if ({rsp_vld, rsp_err, rsp_c, n} !== {2'b11, 32'h7FC00000, 32'd66}) begin fails++; $display("FAIL timeout: got vld=%b err=%b c=%h n=%0d want 1 1 7fc00000 66", rsp_vld, rsp_err, rsp_c, n); end
    cyc(); never = 0;
    tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL timeout_err_clear: got %b want 0", rsp_err); end
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stale_result();
    test_busy_at_issue();
    test_reset_mid();
`ifdef FP_DIV_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_div_arb.md
Name: fp_div_arb

Overview:
- Round-robin arbiter and sequencer that shares one iterative single-precision divider (the fp_div arg_vld/busy/res_vld/a/b/c interface) among NREQ requesters.
- Accepts one operand pair at a time, launches the divider and waits for completion.
- Returns the quotient tagged with the requester index.
- Sits between the issue stage and the shared divider instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester index; must equal clog2(NREQ), minimum 1.
- TIMEOUT_CYC, 64, watchdog limit in cycles. Used only with FP_DIV_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_vld  in  NREQ  request valid, one per requester
- req_rdy  out  NREQ  request accepted, one-hot pulse
- req_a  in  32*NREQ  dividend; requester i occupies [32*i+31:32*i]
- req_b  in  32*NREQ  divisor, same packing
- rsp_vld  out  1  response valid, one-cycle pulse, no backpressure
- rsp_id  out  IDW  index of the requester being answered
- rsp_c  out  32  quotient
- rsp_err  out  1  watchdog error flag, qualified by rsp_vld
- div_arg_vld  out  1  divider start
- div_busy  in  1  divider busy
- div_res_vld  in  1  divider result valid (level; stays high until the next start)
- div_a  out  32  divider dividend
- div_b  out  32  divider divisor
- div_c  in  32  divider quotient

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high. On reset:
  - state=IDLE, ptr=0
  - all outputs 0; internal operand, id and result registers 0
  - an in-flight divide is abandoned and produces no response
  - the divider is not reset by this block
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_RES, RESP.
- IDLE:
  - Grant g = first i with req_vld[i]=1, searching ptr, ptr+1, ... mod NREQ.
  - In the same cycle, req_rdy[g]=1 combinationally; all other req_rdy bits are 0.
  - Latch req_a[g], req_b[g] and g into op_a, op_b, id. Next state ISSUE.
  - No request pending: stay in IDLE.
- req_rdy is 0 in every state other than IDLE. At most one bit is high per cycle.
- ISSUE:
  - If div_busy=0: drive div_arg_vld=1 for exactly one cycle, then go to WAIT_BUSY.
  - If div_busy=1: hold div_arg_vld=0 and stay in ISSUE.
- div_a and div_b are driven from op_a and op_b continuously from ISSUE until the next grant.
- WAIT_BUSY:
  - Go to WAIT_RES on div_busy=1.
  - A stale div_res_vld=1 from the previous operation is ignored here.
- WAIT_RES:
  - On div_busy=0 and div_res_vld=1: latch div_c into rsp_c. Next state RESP.
- RESP:
  - rsp_vld=1 and rsp_id=id for one cycle; rsp_err=0.
  - ptr <= (id+1) mod NREQ. Next state IDLE.
- Throughput:
  - Minimum request-to-response time is 4 cycles plus divider latency.
  - A new grant is possible in the cycle after RESP.
- Fairness: a requester holding req_vld continuously is served within NREQ grants.
- req_vld deasserted while waiting for a grant: that requester is simply not granted; no error.
- Operands are sampled only in the grant cycle. Later changes on req_a/req_b do not affect an operation in flight.
- rsp_c and rsp_id hold their last values after RESP. rsp_vld and rsp_err return to 0.

Optional Feature:
- Macro FP_DIV_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_BUSY and increments in WAIT_BUSY and WAIT_RES.
  - When it reaches TIMEOUT_CYC, go to RESP with rsp_c=32'h7FC00000 and rsp_err=1.
  - ptr advances normally.
  - A divider completion that arrives later is ignored, because the next WAIT_BUSY requires a fresh busy rise.
- Not defined:
  - No counter logic. rsp_err is tied to 0.
  - WAIT states wait indefinitely.

Test Plan:
- Single request: req_vld[1]=1, a=32'h40400000, b=32'h3F800000; divider model returns c=32'h40400000 after 20 cycles.
  - Expect req_rdy[1] pulse in the grant cycle.
  - Expect div_arg_vld pulse one cycle later, with div_a/div_b equal to the operands.
  - Expect rsp_vld with rsp_id=1, rsp_c=32'h40400000, and ptr=2 afterwards.
- Round robin: all four req_vld held high from reset.
  - Grant order 0,1,2,3,0.
  - rsp_id sequence matches, one response per divide.
- Stale result: model holds div_res_vld=1 between operations; second request issued.
  - No response until the model shows busy=1 then busy=0.
  - Exactly one rsp_vld per grant.
- Divider busy at issue: div_busy forced high for 5 cycles after grant.
  - div_arg_vld stays 0 during those 5 cycles.
  - Asserted on the first cycle busy=0.
- Reset mid-operation: rst asserted for 1 cycle in WAIT_RES.
  - All outputs 0 the next cycle, no rsp_vld.
  - Next grant is to requester 0 when req_vld=4'b1111.
- Timeout (macro defined, TIMEOUT_CYC=64): model never raises busy.
  - rsp_vld at 64 cycles after WAIT_BUSY entry, rsp_err=1, rsp_c=32'h7FC00000.
